div_unit: RTL

Sequential 32-bit divide/remainder unit for the RV32IM execute stage. It sits beside the single-cycle ALU and takes over the DIV, DIVU, REM and REMU opcodes, using the same 5-bit opcode encoding. It accepts one operation through a ready/valid handshake and produces the result after a fixed multi-cycle restoring division. The hazard unit stalls the pipeline while the operation is outstanding.

---
 rtl/rv32_pkg.sv | 20 ++
 rtl/div_step.sv | 24 ++
 rtl/div_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: ALU opcode encodings used by the ALU, control unit
// and divider, plus the divider state encoding.
package rv32_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01110;
    localparam logic [4:0] ALU_REMU = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_opcode(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor, so a non-negative difference always fits in WIDTH bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Sequential restoring divide/remainder unit for DIV, DIVU, REM and REMU.
// Handshakes: a request transfers on start && ready; a result on out_valid && out_ready.
module div_unit
    import rv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output div_state_t       dbg_state
);

    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [5:0]       LAST_STEP = 6'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [5:0]       step_q, step_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             is_rem_q, is_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;

    logic             is_signed;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] q_final, r_final;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // quo_q starts as the dividend magnitude; each step shifts out its MSB
    // and shifts the new quotient bit in at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .divisor (divisor_q),
        .bit_in  (quo_q[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        is_signed = (opcode == ALU_DIV) || (opcode == ALU_REM);
        abs1      = (is_signed && data1[WIDTH-1]) ? -data1 : data1;
        abs2      = (is_signed && data2[WIDTH-1]) ? -data2 : data2;
        q_final   = q_neg_q ? -quo_q : quo_q;
        r_final   = r_neg_q ? -rem_q : rem_q;

        state_d     = state_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        is_rem_d    = is_rem_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (start && is_div_opcode(opcode)) begin
                    is_rem_d  = (opcode == ALU_REM) || (opcode == ALU_REMU);
                    divisor_d = abs2;
                    step_d    = 6'd0;
                    // Special cases preload the final quotient/remainder unsigned.
                    if (data2 == '0) begin
                        quo_d   = '1;
                        rem_d   = data1;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
                    end else if (is_signed && data1 == MIN_NEG && data2 == '1) begin
                        quo_d   = MIN_NEG;
                        rem_d   = '0;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        quo_d   = abs1;
                        rem_d   = '0;
                        q_neg_d = is_signed && (data1[WIDTH-1] ^ data2[WIDTH-1]);
                        r_neg_d = is_signed && data1[WIDTH-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                if (step_q == LAST_STEP) begin
                    step_d  = 6'd0;
                    state_d = DONE;
                end else begin
                    step_d = step_q + 6'd1;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    result_d    = is_rem_q ? r_final : q_final;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            step_d      = 6'd0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            step_q      <= 6'd0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            is_rem_q    <= is_rem_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = ~ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule
